alu_sequencer: RTL and testbench
================================

# alu_sequencer

Program sequencer for the accumulator breadboard ALU. It holds a small program of {opcode, operand} instructions, clears the accumulator, then issues one instruction per clock to the ALU. It captures the 64-bit result and halts on any ALU error or illegal opcode. It replaces hand-written testbench stimulus, such as the circumference sequence, with a start/busy/done-driven engine that sits between the host and the breadboard's `opcode`/`input1` pins.

## Interface
- `DEPTH`, 16, program memory entries (power of two)
- `AW`, 4, program address width, equal to log2(DEPTH)

Ports:
- `clock`  in  1  sole clock; all state updates on rising edge
- `reset`  in  1  synchronous, active-high
- `prog_we`  in  1  program write strobe; ignored while `busy`
- `prog_addr`  in  AW  program write address
- `prog_data`  in  38  instruction `{save, use_saved, opcode[3:0], operand[31:0]}`
- `start`  in  1  begin execution at address 0; ignored unless in IDLE, DONE or FAULT
- `last_addr`  in  AW  address of the final instruction; sampled with `start`
- `busy`  out  1  high in CLR and EXEC
- `done`  out  1  one-cycle pulse on successful completion
- `alu_opcode`  out  4  to breadboard `opcode`
- `alu_input`  out  32  to breadboard `input1`
- `alu_result`  in  64  breadboard `output1` (combinational, same cycle)
- `alu_error`  in  2  breadboard `error`
- `result`  out  64  last captured ALU result
- `scratch`  out  32  saved value, equal to `result[31:0]` from the last `save` instruction
- `fault_code`  out  2  00 none, 01 ALU error[0], 10 ALU error[1], 11 illegal opcode
- `fault_pc`  out  AW  address of the faulting instruction

## Operation
- States: IDLE, CLR, EXEC, DONE, FAULT.
- **IDLE, DONE, FAULT:**
  - Drive `alu_opcode`=4'b0000 (NOOP) and `alu_input`=0.
  - `start` → CLR. Latch `last_addr`, clear `fault_code`/`fault_pc`, set pc=0.
  - DONE lasts exactly one cycle (`done`=1), then returns to IDLE.
  - FAULT holds until `start` or `reset`.
- **CLR:**
  - Drive `alu_opcode`=4'b1101 (RESET), `alu_input`=0.
  - Next state EXEC.
- **EXEC (pc=k):**
  - Drive `alu_opcode`=mem[k].opcode.
  - Drive `alu_input` = `scratch` if `use_saved`, else mem[k].operand.
  - At the clock edge, register `result`←`alu_result`. If `save` is set, also register `scratch`←`alu_result[31:0]`.
- **Error check (EXEC):**
  - `alu_error[1]`=1 → FAULT, code 10, `fault_pc`=k.
  - `alu_error[1]`=0 and `alu_error[0]`=1 → FAULT, code 01, `fault_pc`=k.
  - `result` and `scratch` are still updated on the faulting cycle.
- **Illegal opcode (1110 or 1111):**
  - Drive NOOP instead; `result`/`scratch` are not updated.
  - Next state FAULT, code 11, `fault_pc`=k.
  - Takes priority over the ALU error check.
- **Otherwise:** k==latched last → DONE, else pc=k+1.
- **Opcode 1101 inside a program:** passed through unchanged; it clears the accumulator.
- Program memory is a plain register array:
  - Write: `prog_we`=1 and `busy`=0 writes `prog_data` to `prog_addr`.
  - Reset does not clear memory contents.

## Timing
- **Reset:**
  - State=IDLE, `busy`=0, `done`=0, `result`=0, `scratch`=0, `fault_code`=0, `fault_pc`=0.
  - `alu_opcode`=0000, `alu_input`=0 on the cycle after reset asserts.
  - Reset mid-run aborts immediately, with no `done` and no fault recorded.
- **Program of N instructions, `start` sampled at edge 0:**
  - CLR during cycle 1.
  - EXEC for instruction k during cycle 2+k.
  - `done` high during cycle N+2.
  - `busy` high during cycles 1..N+1.
  - `result` is final after the edge ending cycle N+1.
- `alu_opcode`/`alu_input` are registered-state decodes: valid for the whole cycle and stable before the edge at which the breadboard accumulator loads.
- `start` held high continuously in DONE re-launches on the DONE cycle, giving back-to-back runs with no IDLE gap.
- `last_addr`=0 runs a single instruction.
- `last_addr`=DEPTH-1 runs all entries with no pc wrap.

## Test plan
- **Circumference run:**
  - Program: ADD 2; MULT 5; MULT 314 with save; DIV 100; `last_addr`=3; start at edge 0.
  - Required: CLR drives 1101 in cycle 1; `done` in cycle 6; `result`=31; `scratch`=3140; `fault_code`=00.
- **Saved-operand run:**
  - Program: ADD with `use_saved`; MOD 100; `last_addr`=1; `scratch`=3140 from the previous run.
  - Required: `alu_input`=3140 in the first EXEC cycle; `result`=40; `done` in cycle 4.
- **ALU error:**
  - Program: ADD 7; DIV 3. Bench forces `alu_error`=2'b10 in the EXEC cycle for pc=1.
  - Required: FAULT, `fault_code`=10, `fault_pc`=1, `done` never asserted, `busy`=0 afterwards.
- **Illegal opcode:**
  - Program: ADD 1; opcode 1111; ADD 1.
  - Required: NOOP driven in place of 1111; `fault_code`=11; `fault_pc`=1; `result`=1.
- **Ignored inputs while busy:**
  - `start` and `prog_we` to address 0 asserted in cycle 3 of the circumference run.
  - Required: the run completes unchanged with `result`=31; mem[0] is still ADD 2.
- **Reset mid-run:**
  - Assert `reset` in cycle 3 of the circumference run.
  - Required next cycle: IDLE, all outputs zero, `alu_opcode`=0000.
  - A fresh `start` then yields `result`=31.

Source files
------------

// File: rtl/alu_sequencer.sv
// alu_sequencer: program sequencer for the accumulator breadboard ALU.
// Holds a small {save, use_saved, opcode, operand} program, clears the ALU
// accumulator, then issues one instruction per clock. Captures the 64-bit
// ALU result and halts on an ALU error or an illegal opcode.
//
// Ports:
//   clock, reset          clock and synchronous active-high reset
//   prog_we/addr/data     program memory write port (ignored while busy)
//   start, last_addr      launch control; last_addr sampled with start
//   busy, done            busy in CLR/EXEC; done is a one-cycle pulse
//   alu_opcode, alu_input drive the breadboard opcode/input1 pins
//   alu_result, alu_error breadboard output1/error (combinational)
//   result, scratch       last captured result / last saved low word
//   fault_code, fault_pc  fault cause and faulting instruction address
module alu_sequencer #(
    parameter int unsigned DEPTH = 16,
    parameter int unsigned AW    = 4,
    localparam int unsigned OPW  = 4,
    localparam int unsigned DW   = 32,
    localparam int unsigned RW   = 64,
    localparam int unsigned IW   = 38
) (
    input  logic           clock,
    input  logic           reset,
    input  logic           prog_we,
    input  logic [AW-1:0]  prog_addr,
    input  logic [IW-1:0]  prog_data,
    input  logic           start,
    input  logic [AW-1:0]  last_addr,
    output logic           busy,
    output logic           done,
    output logic [OPW-1:0] alu_opcode,
    output logic [DW-1:0]  alu_input,
    input  logic [RW-1:0]  alu_result,
    input  logic [1:0]     alu_error,
    output logic [RW-1:0]  result,
    output logic [DW-1:0]  scratch,
    output logic [1:0]     fault_code,
    output logic [AW-1:0]  fault_pc
);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CLR,
        ST_EXEC,
        ST_DONE,
        ST_FAULT
    } state_t;

    typedef struct packed {
        logic           save;
        logic           use_saved;
        logic [OPW-1:0] opcode;
        logic [DW-1:0]  operand;
    } instr_t;

    localparam logic [OPW-1:0] OP_NOOP  = 4'b0000;
    localparam logic [OPW-1:0] OP_RESET = 4'b1101;

    localparam logic [1:0] FC_NONE    = 2'b00;
    localparam logic [1:0] FC_ERR0    = 2'b01;
    localparam logic [1:0] FC_ERR1    = 2'b10;
    localparam logic [1:0] FC_ILLEGAL = 2'b11;

    state_t         r_state,      w_state_nxt;
    logic [AW-1:0]  r_pc,         w_pc_nxt;
    logic [AW-1:0]  r_last,       w_last_nxt;
    logic [RW-1:0]  r_result,     w_result_nxt;
    logic [DW-1:0]  r_scratch,    w_scratch_nxt;
    logic [1:0]     r_fault_code, w_fault_code_nxt;
    logic [AW-1:0]  r_fault_pc,   w_fault_pc_nxt;

    instr_t         r_mem [DEPTH];
    instr_t         w_instr;
    logic           w_illegal;
    logic           w_busy;
    logic           w_done;
    logic [OPW-1:0] w_alu_opcode;
    logic [DW-1:0]  w_alu_input;

    // Current instruction; opcodes 1110/1111 have no ALU meaning.
    assign w_instr   = r_mem[r_pc];
    assign w_illegal = (w_instr.opcode[3:1] == 3'b111);

    // Program memory: plain register array, untouched by reset.
    always_ff @(posedge clock) begin
        if (prog_we && !w_busy) begin
            r_mem[prog_addr] <= prog_data;
        end
    end

    // State and datapath registers.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_state      <= ST_IDLE;
            r_pc         <= '0;
            r_last       <= '0;
            r_result     <= '0;
            r_scratch    <= '0;
            r_fault_code <= FC_NONE;
            r_fault_pc   <= '0;
        end else begin
            r_state      <= w_state_nxt;
            r_pc         <= w_pc_nxt;
            r_last       <= w_last_nxt;
            r_result     <= w_result_nxt;
            r_scratch    <= w_scratch_nxt;
            r_fault_code <= w_fault_code_nxt;
            r_fault_pc   <= w_fault_pc_nxt;
        end
    end

    // Next state, datapath updates and ALU drive decoded from registered state.
    always_comb begin
        w_state_nxt      = r_state;
        w_pc_nxt         = r_pc;
        w_last_nxt       = r_last;
        w_result_nxt     = r_result;
        w_scratch_nxt    = r_scratch;
        w_fault_code_nxt = r_fault_code;
        w_fault_pc_nxt   = r_fault_pc;
        w_alu_opcode     = OP_NOOP;
        w_alu_input      = '0;
        w_busy           = 1'b0;
        w_done           = 1'b0;

        case (r_state)
            ST_IDLE, ST_DONE, ST_FAULT: begin
                w_done = (r_state == ST_DONE);
                if (start) begin
                    w_state_nxt      = ST_CLR;
                    w_last_nxt       = last_addr;
                    w_fault_code_nxt = FC_NONE;
                    w_fault_pc_nxt   = '0;
                    w_pc_nxt         = '0;
                end else if (r_state == ST_DONE) begin
                    w_state_nxt = ST_IDLE;
                end
            end

            ST_CLR: begin
                w_busy       = 1'b1;
                w_alu_opcode = OP_RESET;
                w_state_nxt  = ST_EXEC;
            end

            ST_EXEC: begin
                w_busy = 1'b1;
                if (w_illegal) begin
                    // NOOP keeps the accumulator; result/scratch are not captured.
                    w_state_nxt      = ST_FAULT;
                    w_fault_code_nxt = FC_ILLEGAL;
                    w_fault_pc_nxt   = r_pc;
                end else begin
                    w_alu_opcode = w_instr.opcode;
                    w_alu_input  = w_instr.use_saved ? r_scratch : w_instr.operand;
                    w_result_nxt = alu_result;
                    if (w_instr.save) begin
                        w_scratch_nxt = alu_result[DW-1:0];
                    end
                    if (alu_error[1]) begin
                        w_state_nxt      = ST_FAULT;
                        w_fault_code_nxt = FC_ERR1;
                        w_fault_pc_nxt   = r_pc;
                    end else if (alu_error[0]) begin
                        w_state_nxt      = ST_FAULT;
                        w_fault_code_nxt = FC_ERR0;
                        w_fault_pc_nxt   = r_pc;
                    end else if (r_pc == r_last) begin
                        w_state_nxt = ST_DONE;
                    end else begin
                        w_pc_nxt = r_pc + AW'(1);
                    end
                end
            end

            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    assign busy       = w_busy;
    assign done       = w_done;
    assign alu_opcode = w_alu_opcode;
    assign alu_input  = w_alu_input;
    assign result     = r_result;
    assign scratch    = r_scratch;
    assign fault_code = r_fault_code;
    assign fault_pc   = r_fault_pc;

endmodule

// File: tb/tb_alu_sequencer.sv
// tb_alu_sequencer: self-checking bench for alu_sequencer.
// A behavioural breadboard ALU (accumulator + combinational output) sits on
// the DUT's ALU pins. A program-level reference model walks each program with
// plain arithmetic to predict the per-cycle ALU drive, final result, scratch
// and fault outcome. Directed scenarios plus randomized programs.
module tb_alu_sequencer;

    logic        clock;
    logic        reset;
    logic        prog_we;
    logic [3:0]  prog_addr;
    logic [37:0] prog_data;
    logic        start;
    logic [3:0]  last_addr;
    logic        busy;
    logic        done;
    logic [3:0]  alu_opcode;
    logic [31:0] alu_input;
    logic [63:0] alu_result;
    logic [1:0]  alu_error;
    logic [63:0] result;
    logic [31:0] scratch;
    logic [1:0]  fault_code;
    logic [3:0]  fault_pc;

    alu_sequencer #(.DEPTH(16), .AW(4)) dut (
        .clock      (clock),
        .reset      (reset),
        .prog_we    (prog_we),
        .prog_addr  (prog_addr),
        .prog_data  (prog_data),
        .start      (start),
        .last_addr  (last_addr),
        .busy       (busy),
        .done       (done),
        .alu_opcode (alu_opcode),
        .alu_input  (alu_input),
        .alu_result (alu_result),
        .alu_error  (alu_error),
        .result     (result),
        .scratch    (scratch),
        .fault_code (fault_code),
        .fault_pc   (fault_pc)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Breadboard opcode set used by this bench.
    localparam logic [3:0] OP_ADD  = 4'h1;
    localparam logic [3:0] OP_SUB  = 4'h2;
    localparam logic [3:0] OP_MULT = 4'h3;
    localparam logic [3:0] OP_DIV  = 4'h4;
    localparam logic [3:0] OP_MOD  = 4'h5;
    localparam logic [3:0] OP_RST  = 4'hD;

    function automatic logic [63:0] alu_fn(input logic [63:0] a, input logic [3:0] op,
                                           input logic [31:0] x);
        logic [63:0] xe;
        xe = 64'(x);
        case (op)
            OP_ADD:  return a + xe;
            OP_SUB:  return a - xe;
            OP_MULT: return a * xe;
            OP_DIV:  return (xe == 64'd0) ? a : a / xe;
            OP_MOD:  return (xe == 64'd0) ? a : a % xe;
            OP_RST:  return 64'd0;
            default: return a;
        endcase
    endfunction

    // Breadboard: combinational output, accumulator loads it every edge.
    logic [63:0] bb_acc;
    always_comb alu_result = alu_fn(bb_acc, alu_opcode, alu_input);
    always @(posedge clock) bb_acc <= alu_result;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", tag, got, got, exp, exp);
        end
    endtask

    // Mirror of what the program memory should hold.
    logic [37:0] pmem [16];

    // Reference model state carried between runs.
    logic [63:0] m_result;
    logic [31:0] m_scratch;
    logic [1:0]  m_fc;
    logic [3:0]  m_fpc;
    logic        m_done;
    logic [3:0]  exp_op [$];
    logic [31:0] exp_in [$];

    function automatic logic [37:0] mk(input logic sv, input logic us, input logic [3:0] op,
                                       input logic [31:0] opnd);
        return {sv, us, op, opnd};
    endfunction

    // Walk the program instruction by instruction with plain arithmetic.
    task automatic ref_run(input int last, input int err_pc, input logic [1:0] err_v);
        logic [63:0] acc;
        logic [3:0]  op;
        logic [31:0] opnd;
        exp_op.delete();
        exp_in.delete();
        acc    = 64'd0;
        m_fc   = 2'b00;
        m_fpc  = 4'd0;
        m_done = 1'b1;
        for (int k = 0; k <= last; k++) begin
            op = pmem[k][35:32];
            if (op == 4'hE || op == 4'hF) begin
                exp_op.push_back(4'h0);
                exp_in.push_back(32'd0);
                m_fc   = 2'b11;
                m_fpc  = 4'(k);
                m_done = 1'b0;
                break;
            end
            opnd = pmem[k][36] ? m_scratch : pmem[k][31:0];
            exp_op.push_back(op);
            exp_in.push_back(opnd);
            acc      = alu_fn(acc, op, opnd);
            m_result = acc;
            if (pmem[k][37]) m_scratch = acc[31:0];
            if (k == err_pc && err_v != 2'b00) begin
                m_fc   = err_v[1] ? 2'b10 : 2'b01;
                m_fpc  = 4'(k);
                m_done = 1'b0;
                break;
            end
        end
    endtask

    task automatic write_instr(input int a, input logic [37:0] d);
        prog_addr = 4'(a);
        prog_data = d;
        prog_we   = 1'b1;
        @(posedge clock);
        #1;
        prog_we = 1'b0;
        pmem[a] = d;
    endtask

    task automatic load_circ();
        write_instr(0, mk(1'b0, 1'b0, OP_ADD,  32'd2));
        write_instr(1, mk(1'b0, 1'b0, OP_MULT, 32'd5));
        write_instr(2, mk(1'b1, 1'b0, OP_MULT, 32'd314));
        write_instr(3, mk(1'b0, 1'b0, OP_DIV,  32'd100));
    endtask

    // Launch a run and check every cycle: CLR, each EXEC, then DONE or FAULT.
    // poke: cycle number in which start and a write to address 0 are asserted.
    task automatic run(input int last, input int err_pc, input logic [1:0] err_v,
                       input int poke, input string tag);
        ref_run(last, err_pc, err_v);
        start     = 1'b1;
        last_addr = 4'(last);
        @(posedge clock);
        #1;
        start     = 1'b0;
        alu_error = 2'b00;
        @(negedge clock);
        check({tag, ".clr_busy"}, 64'(busy), 64'd1);
        check({tag, ".clr_op"},   64'(alu_opcode), 64'hD);
        check({tag, ".clr_in"},   64'(alu_input), 64'd0);
        for (int i = 0; i < exp_op.size(); i++) begin
            @(posedge clock);
            #1;
            start   = 1'b0;
            prog_we = 1'b0;
            if (i + 2 == poke) begin
                start     = 1'b1;
                prog_we   = 1'b1;
                prog_addr = 4'd0;
                prog_data = mk(1'b0, 1'b0, OP_ADD, 32'd99);
            end
            alu_error = (i == err_pc) ? err_v : 2'b00;
            @(negedge clock);
            check($sformatf("%s.exec%0d_busy", tag, i), 64'(busy), 64'd1);
            check($sformatf("%s.exec%0d_done", tag, i), 64'(done), 64'd0);
            check($sformatf("%s.exec%0d_op", tag, i),   64'(alu_opcode), 64'(exp_op[i]));
            check($sformatf("%s.exec%0d_in", tag, i),   64'(alu_input), 64'(exp_in[i]));
        end
        @(posedge clock);
        #1;
        start     = 1'b0;
        prog_we   = 1'b0;
        alu_error = 2'b00;
        @(negedge clock);
        check({tag, ".end_done"},  64'(done), 64'(m_done));
        check({tag, ".end_busy"},  64'(busy), 64'd0);
        check({tag, ".end_op"},    64'(alu_opcode), 64'd0);
        check({tag, ".result"},    result, m_result);
        check({tag, ".scratch"},   64'(scratch), 64'(m_scratch));
        check({tag, ".fault"},     64'(fault_code), 64'(m_fc));
        check({tag, ".fault_pc"},  64'(fault_pc), 64'(m_fpc));
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clock);
            #1;
            @(negedge clock);
            check("idle.busy",  64'(busy), 64'd0);
            check("idle.done",  64'(done), 64'd0);
            check("idle.op",    64'(alu_opcode), 64'd0);
            check("idle.in",    64'(alu_input), 64'd0);
            check("idle.fault", 64'(fault_code), 64'(m_fc));
        end
    endtask

    int          r_last;
    int          r_err_pc;
    logic [1:0]  r_err_v;
    int          r_sel;
    logic [3:0]  r_op;

    initial begin
        reset     = 1'b1;
        prog_we   = 1'b0;
        prog_addr = 4'd0;
        prog_data = 38'd0;
        start     = 1'b0;
        last_addr = 4'd0;
        alu_error = 2'b00;
        m_result  = 64'd0;
        m_scratch = 32'd0;
        m_fc      = 2'b00;
        m_fpc     = 4'd0;
        m_done    = 1'b0;
        for (int a = 0; a < 16; a++) pmem[a] = 38'd0;

        // Reset state.
        repeat (2) @(posedge clock);
        @(negedge clock);
        check("rst.busy",     64'(busy), 64'd0);
        check("rst.done",     64'(done), 64'd0);
        check("rst.result",   result, 64'd0);
        check("rst.scratch",  64'(scratch), 64'd0);
        check("rst.fault",    64'(fault_code), 64'd0);
        check("rst.fault_pc", 64'(fault_pc), 64'd0);
        check("rst.op",       64'(alu_opcode), 64'd0);
        check("rst.in",       64'(alu_input), 64'd0);
        reset = 1'b0;

        // Circumference run, then an immediate back-to-back relaunch.
        load_circ();
        idle(1);
        run(3, -1, 2'b00, 0, "circ");
        check("circ.result_const",  result, 64'd31);
        check("circ.scratch_const", 64'(scratch), 64'd3140);
        run(3, -1, 2'b00, 0, "b2b");
        check("b2b.result_const", result, 64'd31);
        idle(1);

        // Saved operand feeds the first instruction.
        write_instr(0, mk(1'b0, 1'b1, OP_ADD, 32'd0));
        write_instr(1, mk(1'b0, 1'b0, OP_MOD, 32'd100));
        run(1, -1, 2'b00, 0, "saved");
        check("saved.first_in_const", 64'(exp_in[0]), 64'd3140);
        check("saved.result_const",   result, 64'd40);

        // ALU error[1] on pc=1.
        write_instr(0, mk(1'b0, 1'b0, OP_ADD, 32'd7));
        write_instr(1, mk(1'b0, 1'b0, OP_DIV, 32'd3));
        run(1, 1, 2'b10, 0, "err");
        check("err.fault_const", 64'(fault_code), 64'd2);
        check("err.fpc_const",   64'(fault_pc), 64'd1);
        idle(2);

        // Illegal opcode at pc=1.
        write_instr(0, mk(1'b0, 1'b0, OP_ADD, 32'd1));
        write_instr(1, mk(1'b0, 1'b0, 4'hF,   32'd5));
        write_instr(2, mk(1'b0, 1'b0, OP_ADD, 32'd1));
        run(2, -1, 2'b00, 0, "ill");
        check("ill.result_const", result, 64'd1);
        check("ill.fault_const",  64'(fault_code), 64'd3);
        check("ill.fpc_const",    64'(fault_pc), 64'd1);
        idle(1);

        // start and a program write in cycle 3 are ignored while busy.
        load_circ();
        run(3, -1, 2'b00, 3, "poke");
        check("poke.result_const", result, 64'd31);
        idle(1);
        run(3, -1, 2'b00, 0, "poke_rerun");
        check("poke_rerun.result_const", result, 64'd31);

        // Reset in cycle 3 aborts immediately.
        start     = 1'b1;
        last_addr = 4'd3;
        @(posedge clock);
        #1;
        start = 1'b0;
        @(posedge clock);
        #1;
        @(posedge clock);
        #1;
        reset = 1'b1;
        @(posedge clock);
        #1;
        reset = 1'b0;
        @(negedge clock);
        check("mrst.busy",     64'(busy), 64'd0);
        check("mrst.done",     64'(done), 64'd0);
        check("mrst.op",       64'(alu_opcode), 64'd0);
        check("mrst.in",       64'(alu_input), 64'd0);
        check("mrst.result",   result, 64'd0);
        check("mrst.scratch",  64'(scratch), 64'd0);
        check("mrst.fault",    64'(fault_code), 64'd0);
        check("mrst.fault_pc", 64'(fault_pc), 64'd0);
        m_result  = 64'd0;
        m_scratch = 32'd0;
        m_fc      = 2'b00;
        m_fpc     = 4'd0;
        idle(1);
        run(3, -1, 2'b00, 0, "mrst_rerun");
        check("mrst_rerun.result_const", result, 64'd31);

        // Single-instruction program.
        run(0, -1, 2'b00, 0, "last0");
        check("last0.result_const", result, 64'd2);

        // Full depth, no pc wrap: 1+2+...+16.
        for (int a = 0; a < 16; a++) write_instr(a, mk(1'b0, 1'b0, OP_ADD, 32'(a + 1)));
        run(15, -1, 2'b00, 0, "full");
        check("full.result_const", result, 64'd136);

        // Randomized programs, errors and illegal opcodes.
        for (int t = 0; t < 30; t++) begin
            r_last = $urandom_range(0, 15);
            for (int a = 0; a < 16; a++) begin
                r_sel = $urandom_range(0, 39);
                case (r_sel)
                    0:       r_op = 4'hF;
                    1:       r_op = 4'hE;
                    2:       r_op = OP_RST;
                    3:       r_op = 4'h0;
                    default: r_op = 4'($urandom_range(1, 5));
                endcase
                write_instr(a, mk(($urandom_range(0, 3) == 0), ($urandom_range(0, 3) == 0),
                                  r_op, 32'($urandom_range(0, 12))));
            end
            r_err_pc = ($urandom_range(0, 3) == 0) ? $urandom_range(0, r_last) : -1;
            r_err_v  = 2'($urandom_range(1, 3));
            if ($urandom_range(0, 1) == 1) idle($urandom_range(1, 2));
            run(r_last, r_err_pc, r_err_v, 0, $sformatf("rnd%0d", t));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
